alu_operand_loader: RTL

Sequential front end for the 4-bit decrement ALU stage. It debounces a single board push-button, steps an operand-entry state machine that captures operand A, operand B and the operand-select bit from a shared switch bus, and drives them to the decrementer's A/B/Cin inputs. One cycle later it registers the decrementer's Y/Cout/Zout into stable result and flag outputs for the display/LED stage.

---
 rtl/alu_operand_loader.sv | 117 +++++++++++
 1 files changed

// File: rtl/alu_operand_loader.sv
// Operand-entry front end for the 4-bit decrement ALU stage.
// A debounced push-button steps an FSM that captures A, B and the
// operand select from a shared switch bus. The FSM then registers the
// decrementer's result and flags for the display stage.
module alu_operand_loader #(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic         sel,
  input  logic         btn_raw,
  output logic [N-1:0] a_o,
  output logic [N-1:0] b_o,
  output logic         cin_o,
  input  logic [N-1:0] y_i,
  input  logic         cout_i,
  input  logic         zout_i,
  output logic [N-1:0] result_o,
  output logic         flag_c_o,
  output logic         flag_z_o,
  output logic         result_valid_o,
  output logic [1:0]   state_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    EXEC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  state_t        state;
  logic          sync1, sync2;
  logic          stable, stable_d;
  logic [CW-1:0] cnt;
  logic          press;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // The debounced level follows sync2 only after DEB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      stable_d <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pulse only on the debounced rising edge; a release generates nothing.
  assign press = stable & ~stable_d;

  // Operand-entry FSM with registered operand and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LOAD_A;
      a_o            <= '0;
      b_o            <= '0;
      cin_o          <= 1'b0;
      result_o       <= '0;
      flag_c_o       <= 1'b0;
      flag_z_o       <= 1'b0;
      result_valid_o <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (press) begin
          a_o   <= sw;
          state <= LOAD_B;
        end
        LOAD_B: if (press) begin
          b_o   <= sw;
          cin_o <= sel;
          state <= EXEC;
        end
        // Operands have been stable for a full cycle, so y_i has settled.
        EXEC: begin
          result_o       <= y_i;
          flag_c_o       <= cout_i;
          flag_z_o       <= zout_i;
          result_valid_o <= 1'b1;
          state          <= SHOW;
        end
        SHOW: if (press) begin
          result_valid_o <= 1'b0;
          state          <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign state_o = state;

endmodule
